ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single data RAM between four requesters: CPU data port, screen scanout, keyboard/IO writer and debug/loader port.
- The RAM is four 4K banks, with the bank picked by the top two address bits.
- This block does round-robin arbitration, optional locked bursts, and per-bank one-hot write-enable generation.
- Read data returns with a fixed latency, tagged with the requester ID.

Parameters:
AW, 14, address width; bank = addr[AW-1:AW-2]
DW, 16, data width
MAX_BURST, 4, max consecutive beats per locked grant (1..15)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req  input  4  per-requester request
lock  input  4  per-requester burst request, qualified by req
we  input  4  per-requester write (1) / read (0)
addr  input  4*AW  packed addresses, requester i at [i*AW +: AW]
wdata  input  4*DW  packed write data, requester i at [i*DW +: DW]
gnt  output  4  one-hot; command of requester i taken, present next
rvalid  output  1  read data valid
rid  output  2  requester index for rdata
rdata  output  DW  read data
ram_addr  output  AW  RAM address
ram_wdata  output  DW  RAM write data
ram_load  output  4  one-hot bank write enable, 0 on reads
ram_rdata  input  DW  muxed RAM read data, valid the cycle after ram_addr

Behaviour:
Registers and reset:
- All outputs are registered.
- Reset values: gnt=0, rvalid=0, rid=0, rdata=0, ram_addr=0, ram_wdata=0, ram_load=0.
- Reset also sets state=ARB, last=3 (so requester 0 wins first) and beat=0.
- Reset mid-burst or with a read in flight discards everything; no rvalid is issued for it.

States:
- ARB: if any req, pick the first i with req[i], scanning last+1, last+2, ... mod 4.
  - At the edge, capture addr_i into ram_addr and wdata_i into ram_wdata.
  - ram_load = we[i] ? onehot(addr_i[AW-1:AW-2]) : 0.
  - gnt = onehot(i); beat=1.
  - Go to BURST if lock[i], else ACCESS.
  - If no req: gnt=0, ram_load=0, stay in ARB.
- ACCESS (the gnt cycle): the requester updates or drops its command. The arbiter ignores all req.
  - Next: gnt=0, ram_load=0, last=i, go to ARB.
  - Non-locked throughput is therefore one access per 2 cycles.
- BURST (the gnt cycle of owner i):
  - If req[i] && lock[i] && beat<MAX_BURST: capture the new command of i as in ARB, gnt[i]=1 again, beat+1, stay in BURST. This gives one beat per cycle.
  - Otherwise: gnt=0, ram_load=0, last=i, go to ARB.
  - Other requesters are never granted during a burst.

Read path:
- If gnt[i] is high in cycle t for a read, ram_rdata is valid in t+1.
- It is registered, so rvalid=1, rid=i, rdata=ram_rdata in cycle t+2.
- One rvalid pulse per read beat. Writes never assert rvalid.
- Back-to-back burst reads give rvalid on consecutive cycles.

Other rules:
- lock without req is ignored.
- lock dropping mid-burst ends the burst after the current beat.
- A requester must hold req/we/addr/wdata stable from assertion until it sees gnt.
- gnt is never asserted for a requester whose req was low at the capture edge.
- Only the bank addressed gets ram_load. Address bits below the bank field pass through unchanged.

Test Plan:
- Single read: reset, then req[2]=1, we=0, addr=0x1234 → gnt=0100 one cycle later. ram_addr=0x1234, ram_load=0000. rvalid=1, rid=2, rdata=model[0x1234] exactly 2 cycles after gnt.
- Bank decode on write: req[1] write to 0x3FFF data 0xBEEF, then to 0x0000 data 0x1111 → ram_load=1000 then 0001. Read-back returns 0xBEEF and 0x1111.
- Round-robin: all four req held continuously, non-locked → grant order 0,1,2,3,0,… with gnt every other cycle and never two bits set.
- Locked burst: req[3]+lock[3] held for 6 commands, MAX_BURST=4, req[0] also pending → gnt[3] on 4 consecutive cycles. One idle cycle follows, then gnt[0]; requester 3 is served again only after requester 0.
- Burst cut short: lock[2] deasserted after beat 2 → exactly 2 gnt[2] pulses, then ARB resumes with last=2.
- Reset mid-burst: assert reset in the cycle after a read beat → gnt, rvalid and ram_load stay 0. After release, requester 0 wins the first arbitration with all req high.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 4-bank data RAM between four requesters
// (0 = CPU data, 1 = scanout, 2 = keyboard/IO, 3 = debug/loader).
//
// Round-robin arbitration starting after the last served requester, with
// optional locked bursts of up to MAX_BURST back-to-back beats. Each granted
// command is registered onto the RAM port. Writes raise a one-hot bank
// enable taken from the top two address bits. Read data comes back two
// cycles after gnt, tagged with the requester index.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req/lock/we [3:0]       per-requester request, burst request, write flag
//   addr  [4*AW-1:0]        packed addresses, requester i at [i*AW +: AW]
//   wdata [4*DW-1:0]        packed write data, requester i at [i*DW +: DW]
//   gnt   [3:0]             one-hot: requester i's command was taken
//   rvalid/rid/rdata        tagged read return
//   ram_addr/ram_wdata      registered RAM command
//   ram_load [3:0]          one-hot bank write enable (0 on reads)
//   ram_rdata               RAM read data, valid the cycle after ram_addr
module ram_arbiter #(
  parameter int AW        = 14,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [3:0]      lock,
  input  logic [3:0]      we,
  input  logic [4*AW-1:0] addr,
  input  logic [4*DW-1:0] wdata,
  output logic [3:0]      gnt,
  output logic            rvalid,
  output logic [1:0]      rid,
  output logic [DW-1:0]   rdata,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [3:0]      ram_load,
  input  logic [DW-1:0]   ram_rdata
);

  typedef enum logic [1:0] {ARB, ACCESS, BURST} state_t;

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  state_t          state_q, state_d;
  logic [1:0]      last_q, last_d;
  logic [1:0]      own_q, own_d;
  logic [3:0]      beat_q, beat_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic [3:0]      ram_load_q, ram_load_d;
  // Read tracking: [0] aligns with the gnt cycle, [1] with the cycle
  // ram_rdata is valid; rvalid follows one register later.
  logic [1:0]      vld_pipe_q, vld_pipe_d;
  logic [1:0][1:0] id_pipe_q, id_pipe_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rid_q, rid_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic       found, take;
  logic [1:0] win, tid, cand;

  // Rotating priority: first requester after last_q, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    cand  = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    beat_d  = beat_q;
    take    = 1'b0;
    tid     = own_q;
    case (state_q)
      ARB: begin
        if (found) begin
          take    = 1'b1;
          tid     = win;
          own_d   = win;
          beat_d  = 4'd1;
          state_d = lock[win] ? BURST : ACCESS;
        end
      end
      ACCESS: begin
        // Requester is swapping its command this cycle; ignore req.
        last_d  = own_q;
        state_d = ARB;
      end
      BURST: begin
        if (req[own_q] && lock[own_q] && beat_q < MAXB) begin
          take   = 1'b1;
          beat_d = beat_q + 4'd1;
        end else begin
          last_d  = own_q;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    gnt_d       = take ? (4'b0001 << tid) : 4'b0000;
    ram_addr_d  = take ? addr[tid*AW +: AW] : ram_addr_q;
    ram_wdata_d = take ? wdata[tid*DW +: DW] : ram_wdata_q;
    ram_load_d  = (take && we[tid]) ? (4'b0001 << addr[tid*AW + AW-2 +: 2]) : 4'b0000;

    vld_pipe_d  = {vld_pipe_q[0], take && !we[tid]};
    id_pipe_d   = {id_pipe_q[0], tid};
    rvalid_d    = vld_pipe_q[1];
    rid_d       = vld_pipe_q[1] ? id_pipe_q[1] : rid_q;
    rdata_d     = vld_pipe_q[1] ? ram_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB;
      last_q      <= 2'd3;
      own_q       <= 2'd0;
      beat_q      <= 4'd0;
      gnt_q       <= 4'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_load_q  <= 4'd0;
      vld_pipe_q  <= 2'b00;
      id_pipe_q   <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= 2'd0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      own_q       <= own_d;
      beat_q      <= beat_d;
      gnt_q       <= gnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_load_q  <= ram_load_d;
      vld_pipe_q  <= vld_pipe_d;
      id_pipe_q   <= id_pipe_d;
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_load  = ram_load_q;
  assign rvalid    = rvalid_q;
  assign rid       = rid_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed steps followed by a randomized phase. Each
// requester is a queue of commands; its head is presented while the queue is
// non-empty and popped when the grant is due. A transaction-level model
// (turn-taking by rotation, burst beat counting, a sparse memory map)
// predicts every grant, RAM command and tagged read return.
module tb_ram_arbiter;
  localparam int AW = 14, DW = 16, MAXB = 4;
  localparam int IDLE = 0, SINGLE = 1, LOCKED = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req, lock, we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt;
  logic            rvalid;
  logic [1:0]      rid;
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [3:0]      ram_load;
  logic [DW-1:0]   ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rid(rid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_load(ram_load), .ram_rdata(ram_rdata)
  );

  // Contents of never-written words.
  function automatic logic [15:0] init_val(int a);
    return 16'((a * 40503) ^ 23130);
  endfunction

  function automatic logic [1:0] ld_bank(logic [3:0] ld);
    if (ld[3]) return 2'd3;
    if (ld[2]) return 2'd2;
    if (ld[1]) return 2'd1;
    return 2'd0;
  endfunction

  // Physical RAM: writes land in the bank named by ram_load, reads are muxed
  // by ram_addr and appear one cycle later.
  logic [15:0] ram_mem [16384];
  bit          ram_wr  [16384];
  always @(posedge clk) begin
    if (ram_load != 4'd0) begin
      ram_mem[{ld_bank(ram_load), ram_addr[11:0]}] <= ram_wdata;
      ram_wr[{ld_bank(ram_load), ram_addr[11:0]}]  <= 1'b1;
    end
    ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : init_val(int'(ram_addr));
  end

  typedef struct { logic w; logic lk; logic [13:0] a; logic [15:0] d; } cmd_t;
  typedef struct { int due; int id; logic [15:0] d; } rd_t;

  cmd_t        q[4][$];
  rd_t         rq[$];
  logic [15:0] mm [int];
  int          mode, owner, beats, last, ncyc;
  logic [3:0]  p_gnt, p_load;
  logic [13:0] p_addr;
  logic [15:0] p_wd;
  logic        rst_drv;
  int          passed, total;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(int i, logic w, logic lk, logic [13:0] a, logic [15:0] d);
    cmd_t c;
    c.w = w; c.lk = lk; c.a = a; c.d = d;
    q[i].push_back(c);
  endtask

  task automatic drive();
    reset = rst_drv;
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0) begin
        req[i]              = 1'b1;
        lock[i]             = q[i][0].lk;
        we[i]               = q[i][0].w;
        addr[i*AW +: AW]    = q[i][0].a;
        wdata[i*DW +: DW]   = q[i][0].d;
      end else begin
        req[i]  = 1'b0;
        lock[i] = 1'($urandom_range(0, 1));  // must be ignored without req
        we[i]   = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Decide what the coming edge should produce.
  task automatic predict();
    int gi;
    gi = -1;
    p_gnt = 4'd0;
    p_load = 4'd0;
    if (rst_drv) begin
      mode = IDLE; last = 3; beats = 0;
      rq.delete();
      return;
    end
    case (mode)
      IDLE: begin
        for (int k = 1; k <= 4; k++)
          if (gi < 0 && q[(last + k) % 4].size() > 0) gi = (last + k) % 4;
        if (gi >= 0) begin
          owner = gi; beats = 1;
          mode = q[gi][0].lk ? LOCKED : SINGLE;
        end
      end
      SINGLE: begin last = owner; mode = IDLE; end
      default: begin
        if (q[owner].size() > 0 && q[owner][0].lk && beats < MAXB) begin
          gi = owner; beats++;
        end else begin
          last = owner; mode = IDLE;
        end
      end
    endcase
    if (gi >= 0) begin
      cmd_t c;
      c = q[gi].pop_front();
      p_gnt = 4'(1 << gi);
      p_addr = c.a;
      p_wd = c.d;
      if (c.w) begin
        p_load = 4'(1 << (int'(c.a) >> 12));
        mm[int'(c.a)] = c.d;
      end else begin
        rq.push_back('{due: ncyc + 3, id: gi,
                       d: mm.exists(int'(c.a)) ? mm[int'(c.a)] : init_val(int'(c.a))});
      end
    end
  endtask

  task automatic check();
    logic exp_v;
    rd_t  r;
    chk("gnt", 32'(gnt), 32'(p_gnt));
    chk("ram_load", 32'(ram_load), 32'(p_load));
    if (p_gnt != 4'd0) begin
      chk("ram_addr", 32'(ram_addr), 32'(p_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(p_wd));
    end
    exp_v = (rq.size() > 0) && (rq[0].due == ncyc);
    chk("rvalid", 32'(rvalid), 32'(exp_v));
    if (exp_v) begin
      r = rq.pop_front();
      chk("rid", 32'(rid), 32'(r.id));
      chk("rdata", 32'(rdata), 32'(r.d));
    end
    if (rst_drv) begin
      chk("rst_rid", 32'(rid), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_ram_addr", 32'(ram_addr), 0);
      chk("rst_ram_wdata", 32'(ram_wdata), 0);
    end
  endtask

  task automatic cycle();
    drive();
    predict();
    @(posedge clk);
    #1;
    ncyc++;
    check();
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  initial begin
    passed = 0; total = 0; ncyc = 0;
    mode = IDLE; last = 3; beats = 0; owner = 0;
    req = '0; lock = '0; we = '0; addr = '0; wdata = '0;

    // Reset state.
    rst_drv = 1'b1;
    run(3);
    rst_drv = 1'b0;

    // Single read by requester 2.
    push(2, 1'b0, 1'b0, 14'h1234, 16'h0);
    cycle();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_load", 32'(ram_load), 0);
    run(5);

    // Bank decode on writes, then read-back.
    push(1, 1'b1, 1'b0, 14'h3FFF, 16'hBEEF);
    push(1, 1'b1, 1'b0, 14'h0000, 16'h1111);
    push(1, 1'b0, 1'b0, 14'h3FFF, 16'h0);
    push(1, 1'b0, 1'b0, 14'h0000, 16'h0);
    cycle();
    chk("bank3_load", 32'(ram_load), 32'h8);
    run(2);
    chk("bank0_load", 32'(ram_load), 32'h1);
    run(10);

    // Round robin with everyone requesting.
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++)
        push(i, 1'b0, 1'b0, 14'($urandom_range(0, 16383)), 16'h0);
    run(30);

    // Locked burst by 3 capped at MAXB, with 0 waiting.
    for (int b = 0; b < 6; b++)
      push(3, b[0], 1'b1, 14'(16'h3000 + b), 16'($urandom));
    cycle();
    push(0, 1'b0, 1'b0, 14'h3001, 16'h0);
    run(20);

    // Burst cut short by lock dropping after beat 2, with 3 waiting.
    push(2, 1'b1, 1'b1, 14'h2010, 16'hA5A5);
    push(2, 1'b0, 1'b1, 14'h2010, 16'h0);
    push(2, 1'b0, 1'b0, 14'h2011, 16'h0);
    cycle();
    push(3, 1'b0, 1'b0, 14'h2010, 16'h0);
    run(15);

    // Reset right after a read beat of a burst.
    for (int b = 0; b < 4; b++) push(1, 1'b0, 1'b1, 14'(16'h1100 + b), 16'h0);
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (p_gnt == 4'b0010) break;
    end
    rst_drv = 1'b1;
    run(2);
    rst_drv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      push(i, 1'b0, 1'b0, 14'(16'h0100 + i), 16'h0);
    end
    cycle();
    chk("post_reset_winner", 32'(gnt), 32'h1);
    run(12);

    // Randomized traffic over a small address pool so reads hit writes.
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < 4; i++)
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0)
          push(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               14'({$urandom_range(0, 3), 8'h00, 4'($urandom_range(0, 7))}),
               16'($urandom));
      cycle();
    end
    run(40);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
